// File: rtl/pipelined_logic_unit.sv
// Eight-op bitwise logic unit behind an elastic valid/ready pipeline of STAGES register slices.
// Defining LOGIC_UNIT_STATS_EN adds the op_count and busy observation ports.
module pipelined_logic_unit #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
`ifdef LOGIC_UNIT_STATS_EN
    ,
    output logic [31:0]      op_count,
    output logic             busy
`endif
);

    logic [WIDTH-1:0] f_res;

    always_comb begin
        f_res = '0;
        case (op)
            3'b000:  f_res = ~a;
            3'b001:  f_res = a & b;
            3'b010:  f_res = a | b;
            3'b011:  f_res = a ^ b;
            3'b100:  f_res = ~(a & b);
            3'b101:  f_res = ~(a | b);
            3'b110:  f_res = ~(a ^ b);
            default: f_res = a;
        endcase
    end

    logic [STAGES-1:0]            v_q, v_d;
    logic [STAGES-1:0]            zero_q, zero_d;
    logic [STAGES-1:0][WIDTH-1:0] data_q, data_d;
    logic [STAGES-1:0]            rdy;
    logic [STAGES-1:0]            load;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             up_v;
        logic             up_z;
        logic [WIDTH-1:0] up_d;

        // Closed form of the ready chain: a stage may advance if any later
        // stage has a hole, or the consumer is taking the head beat.
        if (k == STAGES - 1) begin : g_tail
            assign rdy[k] = out_ready;
        end else begin : g_mid
            assign rdy[k] = out_ready | ~(&v_q[STAGES-1:k+1]);
        end

        if (k == 0) begin : g_head
            assign up_v = in_valid;
            assign up_d = f_res;
            assign up_z = (f_res == '0);
        end else begin : g_body
            assign up_v = v_q[k-1];
            assign up_d = data_q[k-1];
            assign up_z = zero_q[k-1];
        end

        assign load[k]   = ~v_q[k] | rdy[k];
        assign v_d[k]    = load[k] ? up_v : v_q[k];
        assign data_d[k] = load[k] ? up_d : data_q[k];
        assign zero_d[k] = load[k] ? up_z : zero_q[k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q    <= '0;
            data_q <= '0;
            zero_q <= '0;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
            zero_q <= zero_d;
        end
    end

    assign in_ready  = load[0];
    assign out_valid = v_q[STAGES-1];
    assign result    = data_q[STAGES-1];
    assign zero      = zero_q[STAGES-1];

`ifdef LOGIC_UNIT_STATS_EN
    logic [31:0] op_count_q, op_count_d;

    assign op_count_d = (out_valid && out_ready) ? op_count_q + 32'd1 : op_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign op_count = op_count_q;
    assign busy     = |v_q;
`endif

endmodule
